// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU pipeline: widths, opcodes, flag indices, FSM states.
package cpu_pkg;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;
endpackage

// File: rtl/alu_mul_seq.sv
// LSB-first shift-add multiplier; one iteration per clock, low DATA_W bits of the product kept.
module alu_mul_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] mcand, mplier, acc;
    logic [CW-1:0]     cnt;

    // done and product are combinational so the caller can register the result on the last iteration edge
    assign product = mplier[0] ? acc + mcand : acc;
    assign done    = busy && (cnt == CW'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end
    end
endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops inline, MUL delegated to the sequential multiplier.
module alu_exec
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    input  logic [3:0]    op,
    input  logic [1:0]    rd,
    input  logic [DW-1:0] rd_q,
    input  logic [DW-1:0] rs_q,
    input  logic [7:0]    imm,
    output logic [DW-1:0] alu_out,
    output logic [3:0]    reg_en,
    output logic          en_out,
    output logic          busy,
    output logic [3:0]    flags
);
    logic [0:0]    state;
    logic [1:0]    cap_rd;
    logic          mul_start, mul_done;
    logic [DW-1:0] mul_prod;
    logic [DW-1:0] res;
    logic [3:0]    fl;
    logic [DW:0]   add_w, sub_w;
    logic [3:0]    sh;
    logic          shl_c, shr_c;

    assign mul_start = (state == ST_IDLE) && en_in && (op == OP_MUL);

    alu_mul_seq #(.DATA_W(DW)) u_mul (
        .clk(clk), .rst(rst), .start(mul_start), .a(rd_q), .b(rs_q),
        .busy(busy), .done(mul_done), .product(mul_prod)
    );

    assign add_w = {1'b0, rd_q} + {1'b0, rs_q};
    assign sub_w = {1'b0, rd_q} - {1'b0, rs_q};
    assign sh    = rs_q[3:0];
    // last bit shifted out; a zero shift amount shifts nothing out
    assign shl_c = (sh == 4'd0) ? 1'b0 : rd_q[5'd16 - {1'b0, sh}];
    assign shr_c = (sh == 4'd0) ? 1'b0 : rd_q[sh - 4'd1];

    always_comb begin
        res = '0;
        fl  = '0;
        case (op)
            OP_ADD: begin
                res = add_w[DW-1:0];
                fl[FLAG_C] = add_w[DW];
                fl[FLAG_V] = (rd_q[DW-1] == rs_q[DW-1]) && (res[DW-1] != rd_q[DW-1]);
            end
            OP_SUB, OP_CMP: begin
                res = sub_w[DW-1:0];
                fl[FLAG_C] = sub_w[DW];
                fl[FLAG_V] = (rd_q[DW-1] != rs_q[DW-1]) && (res[DW-1] != rd_q[DW-1]);
            end
            OP_AND: res = rd_q & rs_q;
            OP_OR:  res = rd_q | rs_q;
            OP_XOR: res = rd_q ^ rs_q;
            OP_NOT: res = ~rd_q;
            OP_SHL: begin
                res = rd_q << sh;
                fl[FLAG_C] = shl_c;
            end
            OP_SHR: begin
                res = rd_q >> sh;
                fl[FLAG_C] = shr_c;
            end
            OP_MOV: res = rs_q;
            OP_LDI: res = DW'(imm);
            default: res = '0;
        endcase
        fl[FLAG_Z] = (res == '0);
        fl[FLAG_N] = res[DW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cap_rd  <= '0;
            alu_out <= '0;
            reg_en  <= '0;
            en_out  <= 1'b0;
            flags   <= '0;
        end else begin
            en_out <= 1'b0;
            reg_en <= '0;
            case (state)
                ST_IDLE: if (en_in) begin
                    if (op == OP_MUL) begin
                        state  <= ST_MUL;
                        cap_rd <= rd;
                    end else begin
                        en_out <= 1'b1;
                        if (op <= OP_LDI) begin
                            alu_out <= res;
                            reg_en  <= 4'(1) << rd;
                        end
                        if (op <= OP_CMP) flags <= fl;
                    end
                end
                default: if (mul_done) begin
                    state   <= ST_IDLE;
                    alu_out <= mul_prod;
                    reg_en  <= 4'(1) << cap_rd;
                    en_out  <= 1'b1;
                    flags   <= {(mul_prod == '0), mul_prod[DW-1], 2'b00};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expectations.
module tb_alu_exec;
    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [15:0] rd_q, rs_q;
    logic [7:0]  imm;
    logic [15:0] alu_out;
    logic [3:0]  reg_en;
    logic        en_out, busy;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    alu_exec dut (
        .clk(clk), .rst(rst), .en_in(en_in), .op(op), .rd(rd), .rd_q(rd_q), .rs_q(rs_q),
        .imm(imm), .alu_out(alu_out), .reg_en(reg_en), .en_out(en_out), .busy(busy), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] o, input logic [1:0] r,
                         input logic [15:0] a, input logic [15:0] b, input logic [7:0] i);
        en_in = e; op = o; rd = r; rd_q = a; rs_q = b; imm = i;
    endtask

    task automatic out_chk(input string tag, input logic [15:0] a, input logic [3:0] re,
                           input logic eo, input logic [3:0] f);
        chk({tag, ".alu_out"}, 32'(alu_out), 32'(a));
        chk({tag, ".reg_en"},  32'(reg_en),  32'(re));
        chk({tag, ".en_out"},  32'(en_out),  32'(eo));
        chk({tag, ".flags"},   32'(flags),   32'(f));
    endtask

    initial begin
        int n;
        int stray;
        rst = 1'b1;
        drive(1'b0, 4'h0, 2'd0, 16'h0, 16'h0, 8'h0);
        @(negedge clk);
        step();
        rst = 1'b0;
        out_chk("reset", 16'h0000, 4'b0000, 1'b0, 4'b0000);
        chk("reset.busy", 32'(busy), 32'd0);

        // ADD signed overflow
        drive(1'b1, 4'h0, 2'd2, 16'h7FFF, 16'h0001, 8'h0);
        step();
        out_chk("add_ovf", 16'h8000, 4'b0100, 1'b1, 4'b0101);
        drive(1'b0, 4'h0, 2'd0, 16'h0, 16'h0, 8'h0);
        step();
        out_chk("idle", 16'h8000, 4'b0000, 1'b0, 4'b0101);

        // ADD unsigned carry to zero
        drive(1'b1, 4'h0, 2'd1, 16'hFFFF, 16'h0001, 8'h0);
        step();
        out_chk("add_carry", 16'h0000, 4'b0010, 1'b1, 4'b1010);

        drive(1'b1, 4'h1, 2'd0, 16'h0003, 16'h0005, 8'h0);
        step();
        out_chk("sub", 16'hFFFE, 4'b0001, 1'b1, 4'b0110);

        drive(1'b1, 4'hA, 2'd1, 16'h1234, 16'h1234, 8'h0);
        step();
        out_chk("cmp", 16'hFFFE, 4'b0000, 1'b1, 4'b1000);

        // back-to-back SHR then SHL
        drive(1'b1, 4'h7, 2'd1, 16'h8001, 16'h0001, 8'h0);
        step();
        out_chk("shr", 16'h4000, 4'b0010, 1'b1, 4'b0010);
        drive(1'b1, 4'h6, 2'd3, 16'h8001, 16'h0000, 8'h0);
        step();
        out_chk("shl0", 16'h8001, 4'b1000, 1'b1, 4'b0100);
        drive(1'b1, 4'h6, 2'd3, 16'h8001, 16'h0001, 8'h0);
        step();
        out_chk("shl1", 16'h0002, 4'b1000, 1'b1, 4'b0010);

        drive(1'b1, 4'hC, 2'd2, 16'h5555, 16'h1111, 8'h0);
        step();
        out_chk("nop", 16'h0002, 4'b0000, 1'b1, 4'b0010);

        drive(1'b1, 4'h9, 2'd2, 16'hFFFF, 16'hFFFF, 8'hA5);
        step();
        out_chk("ldi", 16'h00A5, 4'b0100, 1'b1, 4'b0000);

        // MUL with an ignored issue on the 5th busy cycle
        drive(1'b1, 4'hB, 2'd3, 16'h0123, 16'h0010, 8'h0);
        step();
        n = 0;
        stray = 0;
        while (busy === 1'b1 && n < 40) begin
            if (en_out !== 1'b0 || reg_en !== 4'b0000) stray++;
            if (n == 4) drive(1'b1, 4'h0, 2'd0, 16'h0001, 16'h0001, 8'h0);
            else        drive(1'b0, 4'h0, 2'd0, 16'h0, 16'h0, 8'h0);
            step();
            n++;
        end
        chk("mul.busy_cycles", 32'(n), 32'd16);
        chk("mul.no_output_while_busy", 32'(stray), 32'd0);
        out_chk("mul", 16'h1230, 4'b1000, 1'b1, 4'b0000);
        // issue accepted on the cycle busy falls
        drive(1'b1, 4'h0, 2'd1, 16'h0001, 16'h0001, 8'h0);
        step();
        out_chk("add_after_mul", 16'h0002, 4'b0010, 1'b1, 4'b0000);
        drive(1'b0, 4'h0, 2'd0, 16'h0, 16'h0, 8'h0);
        step();
        chk("after_mul.en_out", 32'(en_out), 32'd0);

        // reset aborts a MUL in flight on its 8th busy cycle
        drive(1'b1, 4'hB, 2'd3, 16'h0123, 16'h0010, 8'h0);
        step();
        drive(1'b0, 4'h0, 2'd0, 16'h0, 16'h0, 8'h0);
        for (int i = 0; i < 7; i++) step();
        chk("mul2.busy_pre_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_chk("mul_rst", 16'h0000, 4'b0000, 1'b0, 4'b0000);
        chk("mul_rst.busy", 32'(busy), 32'd0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (reg_en !== 4'b0000 || en_out !== 1'b0 || busy !== 1'b0) stray++;
        end
        chk("mul_rst.no_writeback", 32'(stray), 32'd0);
        drive(1'b1, 4'h0, 2'd0, 16'h0FFF, 16'h0001, 8'h0);
        step();
        out_chk("add_post_rst", 16'h1000, 4'b0001, 1'b1, 4'b0000);
        drive(1'b0, 4'h0, 2'd0, 16'h0, 16'h0, 8'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
